// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IFU_RD = 3'd1,
        ST_LSU_RD = 3'd2,
        ST_LSU_WR = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    function automatic int wdt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/mem_arb_wdt.sv
// rtl/mem_arb_wdt.sv - transfer watchdog: cycle counter with terminal-count pulse
module mem_arb_wdt
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = wdt_width(TIMEOUT_CYCLES);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end

    // Fires during the TIMEOUT_CYCLES-th enabled cycle since the last clear.
    assign o_tc = i_en && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IFU/LSU arbiter for the shared AXI4 bridge; MEM_ARB_RR_EN selects round-robin ties
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_done,
    output logic                ifu_err,
    input  logic                lsu_req,
    input  logic                lsu_wr,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_done,
    output logic                lsu_err,
    output logic                Read_Start,
    output logic [ADDR_W-1:0]   Read_ADDR,
    input  logic [DATA_W-1:0]   Read_Data,
    input  logic                Finish_Read,
    output logic                Write_Start,
    output logic [ADDR_W-1:0]   Write_ADDR,
    output logic [DATA_W-1:0]   Write_Data,
    output logic [DATA_W/8-1:0] Write_Mask,
    input  logic                Finish_Write,
    output logic                busy
);

    localparam int MASK_W = DATA_W / 8;

    state_t              r_state;
    logic                r_owner;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;
    logic [DATA_W-1:0]   r_ifu_rdata;
    logic [DATA_W-1:0]   r_lsu_rdata;

    logic                w_rd_state;
    logic                w_xfer;
    logic                w_finish;
    logic                w_tc;
    logic                w_grant_lsu;
    logic                w_owner_req;
    logic [DATA_W-1:0]   w_rd_val;

    assign w_rd_state  = (r_state == ST_IFU_RD) || (r_state == ST_LSU_RD);
    assign w_xfer      = w_rd_state || (r_state == ST_LSU_WR);
    assign w_finish    = (r_state == ST_LSU_WR) ? Finish_Write : (w_rd_state && Finish_Read);
    assign w_owner_req = (r_owner == OWN_LSU) ? lsu_req : ifu_req;
    assign w_rd_val    = w_finish ? Read_Data : '0;

`ifdef MEM_ARB_RR_EN
    logic r_last_grant;

    // On a tie, serve whoever was not granted last.
    assign w_grant_lsu = lsu_req && (!ifu_req || (r_last_grant == OWN_IFU));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_last_grant <= OWN_IFU;
        else if ((r_state == ST_IDLE) && (ifu_req || lsu_req))
            r_last_grant <= w_grant_lsu;
    end
`else
    assign w_grant_lsu = lsu_req;
`endif

    mem_arb_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state == ST_IDLE),
        .i_en  (w_xfer),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_IFU;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ifu_req || lsu_req) begin
                        r_owner <= w_grant_lsu;
                        r_err   <= 1'b0;
                        if (w_grant_lsu) begin
                            r_addr  <= lsu_addr;
                            r_wdata <= lsu_wdata;
                            r_wmask <= lsu_wmask;
                            r_state <= lsu_wr ? ST_LSU_WR : ST_LSU_RD;
                        end else begin
                            r_addr  <= ifu_addr;
                            r_wdata <= '0;
                            r_wmask <= '0;
                            r_state <= ST_IFU_RD;
                        end
                    end
                end
                ST_IFU_RD, ST_LSU_RD, ST_LSU_WR: begin
                    // A Finish coinciding with the terminal count is a normal completion.
                    if (w_finish) begin
                        r_state <= ST_DONE;
                    end else if (w_tc) begin
                        r_state <= ST_DONE;
                        r_err   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!w_owner_req)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Completed stores leave lsu_rdata alone; any timeout zeroes the owner's rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ifu_rdata <= '0;
            r_lsu_rdata <= '0;
        end else if (w_xfer && (w_finish || w_tc) && !((r_state == ST_LSU_WR) && w_finish)) begin
            if (r_owner == OWN_IFU)
                r_ifu_rdata <= w_rd_val;
            else
                r_lsu_rdata <= w_rd_val;
        end
    end

    assign Read_Start  = w_rd_state;
    assign Write_Start = (r_state == ST_LSU_WR);
    assign Read_ADDR   = r_addr;
    assign Write_ADDR  = r_addr;
    assign Write_Data  = r_wdata;
    assign Write_Mask  = r_wmask;
    assign ifu_done    = (r_state == ST_DONE) && (r_owner == OWN_IFU);
    assign lsu_done    = (r_state == ST_DONE) && (r_owner == OWN_LSU);
    assign ifu_err     = ifu_done && r_err;
    assign lsu_err     = lsu_done && r_err;
    assign ifu_rdata   = r_ifu_rdata;
    assign lsu_rdata   = r_lsu_rdata;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req = 1'b0;
    logic [63:0] ifu_addr = '0;
    logic [63:0] ifu_rdata;
    logic        ifu_done, ifu_err;
    logic        lsu_req = 1'b0;
    logic        lsu_wr = 1'b0;
    logic [63:0] lsu_addr = '0;
    logic [63:0] lsu_wdata = '0;
    logic [7:0]  lsu_wmask = '0;
    logic [63:0] lsu_rdata;
    logic        lsu_done, lsu_err;
    logic        Read_Start;
    logic [63:0] Read_ADDR;
    logic [63:0] Read_Data = '0;
    logic        Finish_Read = 1'b0;
    logic        Write_Start;
    logic [63:0] Write_ADDR, Write_Data;
    logic [7:0]  Write_Mask;
    logic        Finish_Write = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rdata(ifu_rdata),
        .ifu_done(ifu_done), .ifu_err(ifu_err),
        .lsu_req(lsu_req), .lsu_wr(lsu_wr), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_rdata(lsu_rdata),
        .lsu_done(lsu_done), .lsu_err(lsu_err),
        .Read_Start(Read_Start), .Read_ADDR(Read_ADDR), .Read_Data(Read_Data),
        .Finish_Read(Finish_Read),
        .Write_Start(Write_Start), .Write_ADDR(Write_ADDR), .Write_Data(Write_Data),
        .Write_Mask(Write_Mask), .Finish_Write(Finish_Write),
        .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Per-requester transaction (0 = IFU, 1 = LSU); delay 0 means the bridge never answers.
    logic [63:0] t_addr[2];
    logic [63:0] t_wdata[2];
    logic [63:0] t_rdata[2];
    logic [7:0]  t_mask[2];
    bit          t_wr[2];
    int          t_delay[2];

    logic [63:0] m_rdata[2];
    int          m_last;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick_first(input bit wi, input bit wl);
        if (wi && !wl) return 0;
        if (wl && !wi) return 1;
`ifdef MEM_ARB_RR_EN
        return (m_last == 1) ? 0 : 1;
`else
        return 1;
`endif
    endfunction

    task automatic rand_txn(input int o);
        t_addr[o]    = {$urandom, $urandom};
        t_addr[o][0] = (o == 1);
        t_wdata[o]   = {$urandom, $urandom};
        t_rdata[o]   = {$urandom, $urandom};
        t_mask[o]    = 8'($urandom);
        t_wr[o]      = (o == 1) && ($urandom_range(0, 1) == 1);
        case ($urandom_range(0, 9))
            0:       t_delay[o] = 0;
            1:       t_delay[o] = TMO;
            default: t_delay[o] = $urandom_range(1, 5);
        endcase
    endtask

    task automatic serve(input int o);
        bit    rd;
        int    k;
        int    exp_k;
        bit    exp_err;
        string p;
        p       = (o == 1) ? "lsu" : "ifu";
        rd      = (o == 0) || !t_wr[1];
        m_last  = o;
        exp_k   = (t_delay[o] == 0) ? TMO : t_delay[o];
        exp_err = (t_delay[o] == 0);
        k = 0;
        @(negedge clk);
        while ((rd ? Read_Start : Write_Start) && (k < TMO + 2)) begin
            k++;
            check_eq({p, "_other_start"}, rd ? Write_Start : Read_Start, 1'b0);
            check_eq({p, "_addr"}, rd ? Read_ADDR : Write_ADDR, t_addr[o]);
            if (!rd) begin
                check_eq("lsu_wdata_out", Write_Data, t_wdata[1]);
                check_eq("lsu_wmask_out", {56'd0, Write_Mask}, {56'd0, t_mask[1]});
            end
            Finish_Read  = 1'b0;
            Finish_Write = 1'b0;
            Read_Data    = {$urandom, $urandom};
            if (k == t_delay[o]) begin
                if (rd) begin
                    Finish_Read = 1'b1;
                    Read_Data   = t_rdata[o];
                end else begin
                    Finish_Write = 1'b1;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                if (rd) Finish_Write = 1'b1;
                else    Finish_Read  = 1'b1;
            end
            @(negedge clk);
        end
        Finish_Read  = 1'b0;
        Finish_Write = 1'b0;
        check_eq({p, "_start_cycles"}, k, exp_k);
        if (exp_err)  m_rdata[o] = '0;
        else if (rd)  m_rdata[o] = t_rdata[o];
        check_eq({p, "_done"}, (o == 1) ? lsu_done : ifu_done, 1'b1);
        check_eq({p, "_other_done"}, (o == 1) ? ifu_done : lsu_done, 1'b0);
        check_eq({p, "_err"}, (o == 1) ? lsu_err : ifu_err, exp_err);
        check_eq("ifu_rdata", ifu_rdata, m_rdata[0]);
        check_eq("lsu_rdata", lsu_rdata, m_rdata[1]);
        check_eq("busy_done", busy, 1'b1);
        if (o == 1) lsu_req = 1'b0;
        else        ifu_req = 1'b0;
        @(negedge clk);
        check_eq("busy_idle", busy, 1'b0);
        check_eq("done_idle", ifu_done | lsu_done, 1'b0);
    endtask

    task automatic do_round(input bit wi, input bit wl);
        int first;
        ifu_addr  = t_addr[0];
        lsu_addr  = t_addr[1];
        lsu_wr    = t_wr[1];
        lsu_wdata = t_wdata[1];
        lsu_wmask = t_mask[1];
        ifu_req   = wi;
        lsu_req   = wl;
        first = pick_first(wi, wl);
        serve(first);
        if (wi && wl) serve(1 - first);
    endtask

    initial begin
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        m_last     = 0;
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rstart", Read_Start, 1'b0);
        check_eq("rst_wstart", Write_Start, 1'b0);
        check_eq("rst_ifu_rdata", ifu_rdata, 64'd0);
        check_eq("rst_lsu_rdata", lsu_rdata, 64'd0);
        check_eq("rst_done", ifu_done | lsu_done | ifu_err | lsu_err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        rand_txn(0);
        t_addr[0]  = 64'h8000_0000;
        t_rdata[0] = 64'h0000_0013_0000_0297;
        t_delay[0] = 3;
        do_round(1'b1, 1'b0);

        rand_txn(1);
        t_addr[1]  = 64'h8000_1000;
        t_wdata[1] = 64'hDEAD_BEEF;
        t_mask[1]  = 8'h0F;
        t_wr[1]    = 1'b1;
        t_delay[1] = 2;
        do_round(1'b0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            rand_txn(0);
            rand_txn(1);
            t_delay[0] = $urandom_range(1, 4);
            t_delay[1] = $urandom_range(1, 4);
            do_round(1'b1, 1'b1);
        end

        rand_txn(1);
        t_wr[1]    = 1'b0;
        t_delay[1] = 0;
        do_round(1'b0, 1'b1);

        rand_txn(0);
        t_delay[0] = TMO;
        do_round(1'b1, 1'b0);

        rand_txn(0);
        ifu_addr = t_addr[0];
        ifu_req  = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_rstart", Read_Start, 1'b0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_addr", Read_ADDR, 64'd0);
        check_eq("arst_ifu_rdata", ifu_rdata, 64'd0);
        check_eq("arst_lsu_rdata", lsu_rdata, 64'd0);
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        m_last     = 0;
        @(negedge clk);
        @(negedge clk);
        ifu_req = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rand_txn(0);
        t_addr[0]  = 64'h8000_0004;
        t_delay[0] = 2;
        do_round(1'b1, 1'b0);

        for (int r = 0; r < 40; r++) begin
            int sel;
            sel = $urandom_range(1, 3);
            rand_txn(0);
            rand_txn(1);
            do_round(sel[0], sel[1]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
